seq_multiplier: RTL

Iterative signed 64×64→128 shift-add multiplier, the multiply-side counterpart to the team's iterative divider in the execute stage's long-latency integer unit. It accepts one operand pair through the same valid_in/valid_out pulse handshake as the divider and produces the full-width product after a fixed latency. It converts operands to magnitudes, accumulates one multiplier bit per cycle, and applies the result sign at the end.

---
 rtl/mul_pkg.sv | 7 +
 rtl/seq_multiplier_if.sv | 12 +
 rtl/seq_mul_negate.sv | 8 +
 rtl/seq_multiplier.sv | 69 ++++++
 4 files changed

// File: rtl/mul_pkg.sv
// mul_pkg: shared width, counter width and FSM state encoding for the
// iterative multiplier.
package mul_pkg;
   localparam int MUL_WIDTH = 64;
   localparam int CNT_W = $clog2(MUL_WIDTH);
   typedef enum logic [2:0] {IDLE, ABS, CALC, FIX, DONE} state_t;
endpackage

// File: rtl/seq_multiplier_if.sv
// seq_multiplier_if: operand/result handshake bundle between the issuing stage
// and the multiplier.
interface seq_multiplier_if import mul_pkg::*; #(parameter int W = MUL_WIDTH);
   logic           valid_in;
   logic [W-1:0]   multiplicand;
   logic [W-1:0]   multiplier;
   logic [2*W-1:0] product;
   logic           valid_out;
   logic           busy;
   modport master (output valid_in, multiplicand, multiplier, input product, valid_out, busy);
   modport slave (input valid_in, multiplicand, multiplier, output product, valid_out, busy);
endinterface

// File: rtl/seq_mul_negate.sv
// seq_mul_negate: conditional two's-complement negator, dout = en ? -din : din.
module seq_mul_negate #(parameter int W = 64) (
   input  logic         en,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout
);
   assign dout = en ? ~din + W'(1) : din;
endmodule

// File: rtl/seq_multiplier.sv
// seq_multiplier: iterative 64x64->128 shift-add multiplier with a fixed latency.
// Signed operands when SEQ_MUL_SIGNED_EN is defined, unsigned otherwise.
module seq_multiplier import mul_pkg::*; (
   input logic clk,
   input logic rst,
   seq_multiplier_if.slave bus
);
   localparam int W = MUL_WIDTH;
   state_t         state;
   logic [W-1:0]   a_r, b_r, mcand, mplr, a_mag, b_mag;
   logic [2*W-1:0] acc, p_fix;
   logic [CNT_W-1:0] cnt;
   logic [W:0]     sum;
   logic           neg, neg_a, neg_b;
`ifdef SEQ_MUL_SIGNED_EN
   assign neg_a = a_r[W-1];
   assign neg_b = b_r[W-1];
`else
   assign neg_a = 1'b0;
   assign neg_b = 1'b0;
`endif
   seq_mul_negate #(.W(W))   u_neg_a (.en(neg_a), .din(a_r), .dout(a_mag));
   seq_mul_negate #(.W(W))   u_neg_b (.en(neg_b), .din(b_r), .dout(b_mag));
   seq_mul_negate #(.W(2*W)) u_neg_p (.en(neg), .din(acc), .dout(p_fix));
   // the carry out of the upper-half add becomes the new MSB after the shift
   assign sum = {1'b0, acc[2*W-1:W]} + (mplr[0] ? {1'b0, mcand} : '0);
   always_ff @(posedge clk)
      if (rst) begin
         state         <= IDLE;
         bus.product   <= '0;
         bus.valid_out <= 1'b0;
         bus.busy      <= 1'b0;
         cnt           <= '0;
         neg           <= 1'b0;
      end else
         case (state)
            IDLE: if (bus.valid_in) begin
               a_r      <= bus.multiplicand;
               b_r      <= bus.multiplier;
               bus.busy <= 1'b1;
               state    <= ABS;
            end
            ABS: begin
               neg   <= neg_a ^ neg_b;
               mcand <= a_mag;
               mplr  <= b_mag;
               acc   <= '0;
               cnt   <= '0;
               state <= CALC;
            end
            CALC: begin
               acc   <= {sum, acc[W-1:1]};
               mplr  <= {acc[0], mplr[W-1:1]};
               cnt   <= cnt + CNT_W'(1);
               state <= cnt == CNT_W'(W-1) ? FIX : CALC;
            end
            FIX: begin
               bus.product   <= p_fix;
               bus.valid_out <= 1'b1;
               state         <= DONE;
            end
            DONE: begin
               bus.valid_out <= 1'b0;
               bus.busy      <= 1'b0;
               state         <= IDLE;
            end
            default: state <= IDLE;
         endcase
endmodule
